// File: rtl/spi_master.sv
// ============================================================================
// Module   : spi_master
// Purpose  : Mode-0 SPI master, WIDTH bits per transaction, SCLK half-period
//            of CLK_DIV clk cycles. Define SPI_MASTER_LSB_FIRST_EN for LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic [WIDTH-1:0] rxData,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_ALL  = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_TRANSFER = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rxdata_q, rxdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;

  logic [WIDTH-1:0] w_tx_adv;
  logic [WIDTH-1:0] w_rx_in;
  logic             w_first_load;
  logic             w_first_adv;
  logic             w_div_end;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_tx_adv     = {1'b0, tx_q[WIDTH-1:1]};
  assign w_rx_in      = {miso, rx_q[WIDTH-1:1]};
  assign w_first_load = txData[0];
  assign w_first_adv  = w_tx_adv[0];
`else
  assign w_tx_adv     = {tx_q[WIDTH-2:0], 1'b0};
  assign w_rx_in      = {rx_q[WIDTH-2:0], miso};
  assign w_first_load = txData[WIDTH-1];
  assign w_first_adv  = w_tx_adv[WIDTH-1];
`endif

  assign w_div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;

    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          tx_d    = txData;
          div_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = w_first_load;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = w_rx_in;
          state_d = S_TRANSFER;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_TRANSFER: begin
        if (w_div_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            tx_d   = w_tx_adv;
            mosi_d = w_first_adv;
            bit_d  = bit_q + 1'b1;
          end else if (bit_q == BIT_ALL) begin
            // last low half-period has elapsed; sclk stays low into HOLD
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b1;
            rx_d   = w_rx_in;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (w_div_end) begin
          div_d    = '0;
          cs_d     = 1'b1;
          rxdata_d = rx_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
    end
  end

  assign rxData = rxdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sclk   = sclk_q;
  assign cs     = cs_q;
  assign mosi   = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Directed self-checking bench for spi_master (WIDTH=8, CLK_DIV=4)
//            with a scoreboard of expected rxData / mosi sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] txData;
  logic [W-1:0] rxData;
  logic         busy;
  logic         done;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic         loopback;
  logic         miso_level;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : miso_level;

  spi_master #(.WIDTH(W), .CLK_DIV(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .txData (txData),
    .rxData (rxData),
    .busy   (busy),
    .done   (done),
    .sclk   (sclk),
    .cs     (cs),
    .mosi   (mosi),
    .miso   (miso)
  );

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] mseq;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Line statistics gathered on the falling clk edge
  int           rise_cnt   = 0;
  int           done_cnt   = 0;
  int           cs_low_cnt = 0;
  logic         prev_sclk  = 1'b0;
  logic [W-1:0] mosi_seq   = '0;

  always @(negedge clk) begin
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_cnt = rise_cnt + 1;
      mosi_seq = {mosi_seq[W-2:0], mosi};
    end
    prev_sclk = sclk;
    if (cs === 1'b0) cs_low_cnt = cs_low_cnt + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  // mosi_seq holds the first transmitted bit in its MSB
  function automatic logic [W-1:0] mseq_of(input logic [W-1:0] tx);
    logic [W-1:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < W; i++) r[W-1-i] = tx[i];
`else
    r = tx;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] rx_exp, input logic [W-1:0] tx);
    exp_t e;
    e.rx   = rx_exp;
    e.mseq = mseq_of(tx);
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_rx"}, {24'd0, rxData}, {24'd0, e.rx});
        check({tag, "_mosi_seq"}, {24'd0, mosi_seq}, {24'd0, e.mseq});
      end
    end
  endtask

  int r0, c0, d0;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    txData     = '0;
    loopback   = 1'b1;
    miso_level = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs",   {31'd0, cs},   32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rx",   {24'd0, rxData}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cs", {31'd0, cs}, 32'd1);

    // Loopback A5: timing, bit order, pulse width
    #1; r0 = rise_cnt; c0 = cs_low_cnt; d0 = done_cnt;
    @(negedge clk);
    txData = 8'hA5; start = 1'b1; push(8'hA5, 8'hA5);
    @(negedge clk);
    start = 1'b0;
    check("a5_accept_busy", {31'd0, busy}, 32'd1);
    check("a5_accept_cs",   {31'd0, cs},   32'd0);
    check("a5_accept_sclk", {31'd0, sclk}, 32'd0);
    wait_done("a5");
    check("a5_done_cs",   {31'd0, cs},   32'd1);
    check("a5_done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    check("a5_done_width", {31'd0, done}, 32'd0);
    check("a5_rises",  rise_cnt - r0,   32'd8);
    check("a5_cs_low", cs_low_cnt - c0, 32'd72);
    check("a5_dones",  done_cnt - d0,   32'd1);

    // miso tied high, zero data
    loopback = 1'b0; miso_level = 1'b1;
    r0 = rise_cnt;
    @(negedge clk);
    txData = 8'h00; start = 1'b1; push(8'hFF, 8'h00);
    @(negedge clk);
    start = 1'b0;
    wait_done("ones");
    @(negedge clk); #1;
    check("ones_rises", rise_cnt - r0, 32'd8);

    // start while busy and txData changes are ignored
    loopback = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    txData = 8'h5A; start = 1'b1; push(8'h5A, 8'h5A);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    txData = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    repeat (120) @(negedge clk);
    #1;
    check("ign_dones", done_cnt - d0, 32'd1);
    check("ign_idle_busy", {31'd0, busy}, 32'd0);

    // reset mid-transaction aborts
    @(negedge clk);
    txData = 8'h96; start = 1'b1; push(8'h96, 8'h96);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_cs",   {31'd0, cs},   32'd1);
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_rx",   {24'd0, rxData}, 32'd0);
    reset = 1'b0; start = 1'b0;
    sb.delete();
    #1; d0 = done_cnt;
    repeat (100) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_rx_hold", {24'd0, rxData}, 32'd0);

    // back-to-back with start held across done
    r0 = rise_cnt; c0 = cs_low_cnt;
    @(negedge clk);
    txData = 8'h3C; start = 1'b1; push(8'h3C, 8'h3C); push(8'hC3, 8'hC3);
    @(negedge clk);
    txData = 8'hC3;
    wait_done("b2b1");
    check("b2b1_cs_high", {31'd0, cs}, 32'd1);
    #1;
    check("b2b1_cs_low", cs_low_cnt - c0, 32'd72);
    @(negedge clk);
    check("b2b_cs_gap_low", {31'd0, cs},   32'd0);
    check("b2b_done_width", {31'd0, done}, 32'd0);
    wait_done("b2b2");
    start = 1'b0;
    @(negedge clk); #1;
    check("b2b_rises", rise_cnt - r0, 32'd16);
    check("b2b_stop_busy", {31'd0, busy}, 32'd0);

    // single set bit shows bit ordering
    @(negedge clk);
    txData = 8'h01; start = 1'b1; push(8'h01, 8'h01);
    @(negedge clk);
    start = 1'b0;
    wait_done("one_bit");

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per transaction (minimum 2).
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (minimum 1).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, meaning request a transaction; sampled only in IDLE.
REQ-006 SHALL have port txData, input, WIDTH, meaning the word to transmit; captured on start acceptance.
REQ-007 SHALL have port rxData, output, WIDTH, meaning the last fully received word.
REQ-008 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse at transaction end.
REQ-010 SHALL have port sclk, output, 1, meaning the serial clock; idles low (mode 0).
REQ-011 SHALL have port cs, output, 1, meaning the active-low chip select.
REQ-012 SHALL have port mosi, output, 1, meaning serial data to the peripheral.
REQ-013 SHALL have port miso, input, 1, meaning serial data from the peripheral.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETUP, TRANSFER and HOLD, all outputs registered.
REQ-015 IDLE, start=1: SHALL load txData into the tx shift register, clear the divider and bit counters, drive cs=0 and set busy=1 at the next edge, and enter SETUP.
REQ-016 IDLE, start=0: SHALL hold cs=1, sclk=0 and busy=0.
REQ-017 SHALL drive mosi from the current first-to-send bit of the tx shift register from the SETUP entry edge onward.
REQ-018 SETUP: after CLK_DIV cycles, SHALL set sclk=1 and enter TRANSFER.
REQ-019 TRANSFER: sclk SHALL toggle every CLK_DIV cycles.
REQ-020 On the edge that takes sclk 0->1, SHALL shift miso into the rx shift register.
REQ-021 On the edge that takes sclk 1->0, SHALL advance the tx shift register and increment the bit counter.
REQ-022 After the WIDTH-th sclk falling edge, SHALL enter HOLD with sclk=0.
REQ-023 HOLD: after CLK_DIV cycles, SHALL drive cs=1, copy the rx shift register to rxData, pulse done=1 for one cycle, clear busy, and enter IDLE.
REQ-024 SHALL keep cs low for exactly (2*WIDTH+2)*CLK_DIV cycles and produce exactly WIDTH sclk rising edges per transaction.
REQ-025 start while busy=1 SHALL be ignored, not queued; changes to txData during a transaction SHALL have no effect.
REQ-026 start asserted in the done cycle SHALL be accepted, giving back-to-back transactions with cs high for exactly one cycle.
REQ-027 rxData SHALL change only in a done cycle or on reset.

Reset
REQ-028 While reset=1, SHALL force IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rxData=0, and clear all counters and shift registers.
REQ-029 reset mid-transaction SHALL abort at the next edge with no done pulse and rxData=0.
REQ-030 reset SHALL take priority over start.

Configuration
REQ-031 Macro SPI_MASTER_LSB_FIRST_EN, when defined, SHALL transmit and receive bit 0 first.
REQ-032 When SPI_MASTER_LSB_FIRST_EN is undefined, SHALL transmit and receive MSB first (bit WIDTH-1 first); all timing SHALL be identical in both builds.

Verification
REQ-033 Loopback (miso=mosi), WIDTH=8, CLK_DIV=4, txData=8'hA5, start pulse -> mosi sequence 1,0,1,0,0,1,0,1; rxData=8'hA5; done one cycle; cs low 72 cycles.
REQ-034 miso tied 1, txData=8'h00 -> rxData=8'hFF; exactly 8 sclk rising edges.
REQ-035 Second start pulse 10 cycles into a transaction -> ignored; exactly one done pulse.
REQ-036 reset=1 at cycle 30 of a transaction -> next edge cs=1, sclk=0, busy=0, no done pulse, rxData=8'h00.
REQ-037 start held high across done, txData 8'h3C then 8'hC3 in loopback -> two done pulses, cs high exactly one cycle between, rxData 8'h3C then 8'hC3.
REQ-038 SPI_MASTER_LSB_FIRST_EN defined, loopback, txData=8'h01 -> first mosi bit 1, remaining bits 0, rxData=8'h01.
